// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: PC advance, IF/ID hold, ID/EX bubbles, branch flush,
// scoreboard RAW interlock (no forwarding), start/halt/drain FSM and saturating stall/flush counters.
module pipe_seq_ctrl #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int WB_BYPASS    = 0,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_reg_wr,
  input  logic [REG_W-1:0] id_dst,
  input  logic             ex_branch,
  input  logic             ex_taken,
  output logic             pc_en,
  output logic             pc_sel_br,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int   DW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic BYP = (WB_BYPASS != 0);

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             ex_vld_q, ex_vld_d, mem_vld_q, mem_vld_d, wr_vld_q, wr_vld_d;
  logic [REG_W-1:0] ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d, wr_dst_q, wr_dst_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             done_q, done_d;

  logic rs_hit, rt_hit, stall, flush, issue, in_run;

  assign in_run = (state_q == S_RUN);

  // The WR entry only counts when the register file cannot write-before-read.
  assign rs_hit = (id_rs != '0) &
                  ((ex_vld_q  & (ex_dst_q  == id_rs)) |
                   (mem_vld_q & (mem_dst_q == id_rs)) |
                   (~BYP & wr_vld_q & (wr_dst_q == id_rs)));
  assign rt_hit = (id_rt != '0) &
                  ((ex_vld_q  & (ex_dst_q  == id_rt)) |
                   (mem_vld_q & (mem_dst_q == id_rt)) |
                   (~BYP & wr_vld_q & (wr_dst_q == id_rt)));

  assign stall = in_run & ((id_use_rs & rs_hit) | (id_use_rt & rt_hit));
  // Reset masks the redirect so the PC mux is quiet while rst is held.
  assign flush = ex_branch & ex_taken & ~rst;
  assign issue = in_run & ~stall & ~flush;

  always_comb begin
    pc_en       = 1'b0;
    pc_sel_br   = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (in_run) begin
      if (flush) begin
        pc_en       = 1'b1;
        pc_sel_br   = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (stall) begin
        idex_bubble = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end else begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (flush) begin
        pc_en     = 1'b1;
        pc_sel_br = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ex_vld_d  = issue & id_reg_wr & (id_dst != '0);
    ex_dst_d  = id_dst;
    mem_vld_d = ex_vld_q;
    mem_dst_d = ex_dst_q;
    wr_vld_d  = mem_vld_q;
    wr_dst_d  = mem_dst_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall & ~flush & (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush & (flush_cnt_q != '1))          flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      ex_vld_q    <= 1'b0;
      ex_dst_q    <= '0;
      mem_vld_q   <= 1'b0;
      mem_dst_q   <= '0;
      wr_vld_q    <= 1'b0;
      wr_dst_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      ex_vld_q    <= ex_vld_d;
      ex_dst_q    <= ex_dst_d;
      mem_vld_q   <= mem_vld_d;
      mem_dst_q   <= mem_dst_d;
      wr_vld_q    <= wr_vld_d;
      wr_dst_q    <= wr_dst_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign running   = in_run;
  assign done      = done_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
